// File: rtl/gmem_arbiter.sv
// Two-master round-robin arbiter onto a single shared memory port.
// Optional grant timeout enabled by defining GMEM_ARB_TIMEOUT_EN.
module gmem_arbiter #(
  parameter int unsigned AW      = 20,
  parameter int unsigned DW      = 48,
  parameter int unsigned SW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_data_out,
  input  logic          m0_we,
  input  logic          m0_rd,
  input  logic [SW-1:0] m0_sel,
  output logic [DW-1:0] m0_data_in,
  output logic          m0_ready,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_data_out,
  input  logic          m1_we,
  input  logic          m1_rd,
  input  logic [SW-1:0] m1_sel,
  output logic [DW-1:0] m1_data_in,
  output logic          m1_ready,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_data_out,
  output logic          s_we,
  output logic          s_rd,
  output logic [SW-1:0] s_sel,
  input  logic [DW-1:0] s_data_in,
  input  logic          s_ready,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e r_state, w_state_nxt;
  logic   r_last, w_last_nxt;
  logic   w_req0, w_req1, w_tmo;

  assign w_req0 = m0_we | m0_rd;
  assign w_req1 = m1_we | m1_rd;

`ifdef GMEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] r_cnt;

  // Counter holds the number of completed wait cycles, so it reads TIMEOUT-1 in the last one.
  assign w_tmo = (r_state != StIdle) && !s_ready && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == StIdle) begin
      r_cnt <= '0;
    end else if (!s_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT;
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_req0 && w_req1) begin
          w_state_nxt = r_last ? StGnt0 : StGnt1;
        end else if (w_req0) begin
          w_state_nxt = StGnt0;
        end else if (w_req1) begin
          w_state_nxt = StGnt1;
        end
      end
      StGnt0: begin
        if (s_ready || w_tmo) begin
          w_state_nxt = StIdle;
          w_last_nxt  = 1'b0;
        end
      end
      StGnt1: begin
        if (s_ready || w_tmo) begin
          w_state_nxt = StIdle;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    s_addr     = '0;
    s_data_out = '0;
    s_we       = 1'b0;
    s_rd       = 1'b0;
    s_sel      = '0;
    m0_data_in = '0;
    m0_ready   = 1'b0;
    m0_err     = 1'b0;
    m1_data_in = '0;
    m1_ready   = 1'b0;
    m1_err     = 1'b0;
    busy       = 1'b0;
    unique case (r_state)
      StGnt0: begin
        busy       = 1'b1;
        s_addr     = m0_addr;
        s_data_out = m0_data_out;
        s_sel      = m0_sel;
        s_we       = m0_we & ~w_tmo;
        s_rd       = m0_rd & ~w_tmo;
        m0_data_in = s_data_in;
        m0_ready   = s_ready | w_tmo;
        m0_err     = w_tmo;
      end
      StGnt1: begin
        busy       = 1'b1;
        s_addr     = m1_addr;
        s_data_out = m1_data_out;
        s_sel      = m1_sel;
        s_we       = m1_we & ~w_tmo;
        s_rd       = m1_rd & ~w_tmo;
        m1_data_in = s_data_in;
        m1_ready   = s_ready | w_tmo;
        m1_err     = w_tmo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gmem_arbiter.sv
// Directed self-checking bench for gmem_arbiter (TIMEOUT=4 instance).
module tb_gmem_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 48;
  localparam int unsigned SW = 4;

  logic          clk, rst_n;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_data_out, m1_data_out, m0_data_in, m1_data_in, s_data_out, s_data_in;
  logic          m0_we, m0_rd, m1_we, m1_rd, s_we, s_rd, s_ready;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_ready, m0_err, m1_ready, m1_err, busy;

  int n_checks = 0;
  int n_pass   = 0;

  gmem_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_addr    (m0_addr),
    .m0_data_out(m0_data_out),
    .m0_we      (m0_we),
    .m0_rd      (m0_rd),
    .m0_sel     (m0_sel),
    .m0_data_in (m0_data_in),
    .m0_ready   (m0_ready),
    .m0_err     (m0_err),
    .m1_addr    (m1_addr),
    .m1_data_out(m1_data_out),
    .m1_we      (m1_we),
    .m1_rd      (m1_rd),
    .m1_sel     (m1_sel),
    .m1_data_in (m1_data_in),
    .m1_ready   (m1_ready),
    .m1_err     (m1_err),
    .s_addr     (s_addr),
    .s_data_out (s_data_out),
    .s_we       (s_we),
    .s_rd       (s_rd),
    .s_sel      (s_sel),
    .s_data_in  (s_data_in),
    .s_ready    (s_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_data_out = '0; m0_we = 0; m0_rd = 0; m0_sel = '0;
    m1_addr = '0; m1_data_out = '0; m1_we = 0; m1_rd = 0; m1_sel = '0;
    s_data_in = '0; s_ready = 0;
  endtask

  // Leaves time mid-cycle (posedge+3) with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    // Single read from master 0
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_s_rd", s_rd, 0);
    m0_rd = 1; m0_addr = 20'h00010; s_ready = 1; s_data_in = 48'h123456789ABC;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_m0_ready", m0_ready, 0);
    cyc(); @(negedge clk);
    check("g0_busy", busy, 1);
    check("g0_s_rd", s_rd, 1);
    check("g0_s_addr", s_addr, 64'h10);
    check("g0_m0_ready", m0_ready, 1);
    check("g0_m0_data", m0_data_in, 64'h123456789ABC);
    check("g0_m1_ready", m1_ready, 0);
    check("g0_m1_data", m1_data_in, 0);
    m0_rd = 0;
    cyc(); @(negedge clk);
    check("g0_done_busy", busy, 0);
    check("g0_done_ready", m0_ready, 0);

    // Tie after reset, then alternating ties
    do_reset();
    m0_rd = 1; m0_addr = 20'h00100; m1_we = 1; m1_addr = 20'h00200; s_ready = 1;
    @(negedge clk);
    check("tie_idle", busy, 0);
    cyc(); @(negedge clk);
    check("tie1_addr", s_addr, 64'h100);
    check("tie1_m0_ready", m0_ready, 1);
    check("tie1_m1_ready", m1_ready, 0);
    cyc(); m0_rd = 0; @(negedge clk);
    check("tie_gap_busy", busy, 0);
    check("tie_gap_s_we", s_we, 0);
    cyc(); @(negedge clk);
    check("tie2_addr", s_addr, 64'h200);
    check("tie2_s_we", s_we, 1);
    check("tie2_m1_ready", m1_ready, 1);
    m0_rd = 1;
    cyc(); @(negedge clk);
    check("tie2_gap_busy", busy, 0);
    cyc(); @(negedge clk);
    check("tie3_addr", s_addr, 64'h100);
    m0_rd = 0;
    cyc(); @(negedge clk);
    check("tie3_gap_busy", busy, 0);
    cyc(); @(negedge clk);
    check("tie4_addr", s_addr, 64'h200);

    // Long write from master 1 with master 0 waiting
    do_reset();
    m1_we = 1; m1_addr = 20'h0ABCD; m1_data_out = 48'hABCDEF012345; m1_sel = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 1) m0_rd = 1;
      if (i == 6) s_ready = 1;
      @(negedge clk);
      check("wr_addr", s_addr, 64'h0ABCD);
      check("wr_data", s_data_out, 64'hABCDEF012345);
      check("wr_sel", s_sel, 64'hF);
      check("wr_s_we", s_we, 1);
      check("wr_m0_ready", m0_ready, 0);
      check("wr_m1_ready", m1_ready, (i == 6) ? 1 : 0);
    end
    cyc(); m1_we = 0; @(negedge clk);
    check("wr_gap_busy", busy, 0);
    cyc(); @(negedge clk);
    check("wr_m0_granted", s_rd, 1);
    check("wr_m0_ready", m0_ready, 1);

    // Reset asserted during GNT1
    do_reset();
    m1_we = 1; m1_addr = 20'h00055; m1_data_out = 48'h0000_0000_BEEF;
    cyc(); s_ready = 1; #1;
    check("rg1_busy", busy, 1);
    check("rg1_m1_ready", m1_ready, 1);
    rst_n = 0; #1;
    check("rg1_rst_busy", busy, 0);
    check("rg1_rst_s_we", s_we, 0);
    check("rg1_rst_addr", s_addr, 0);
    check("rg1_rst_data", s_data_out, 0);
    check("rg1_rst_ready", m1_ready, 0);
    m0_rd = 1; m0_addr = 20'h00077;
    @(posedge clk); #3 rst_n = 1;
    cyc(); @(negedge clk);
    check("rg1_after_m0", s_addr, 64'h77);
    check("rg1_after_m1_ready", m1_ready, 0);

`ifdef GMEM_ARB_TIMEOUT_EN
    // Timeout fires in the 4th grant cycle
    do_reset();
    m0_rd = 1; m0_addr = 20'h00011;
    for (int i = 1; i <= 4; i++) begin
      cyc(); @(negedge clk);
      check("to_busy", busy, 1);
      check("to_ready", m0_ready, (i == 4) ? 1 : 0);
      check("to_err", m0_err, (i == 4) ? 1 : 0);
      check("to_s_rd", s_rd, (i == 4) ? 0 : 1);
    end
    m0_rd = 0;
    cyc(); @(negedge clk);
    check("to_idle", busy, 0);
    // s_ready coinciding with timeout wins
    do_reset();
    m0_rd = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) s_ready = 1;
      @(negedge clk);
    end
    check("to_tie_ready", m0_ready, 1);
    check("to_tie_err", m0_err, 0);
    check("to_tie_s_rd", s_rd, 1);
`else
    // Without timeout the grant waits indefinitely
    do_reset();
    m0_rd = 1; m0_addr = 20'h00011;
    seen = 0;
    repeat (100) begin
      cyc(); @(negedge clk);
      if (m0_err || m0_ready) seen = 1;
    end
    check("nto_no_done", seen, 0);
    check("nto_busy", busy, 1);
    check("nto_s_rd", s_rd, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
